// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the handshaked register chain.
package pipe_pkg;

  // Default geometry of the chain.
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 3;

  // Supported range of stage counts.
  localparam int MIN_DEPTH = 1;
  localparam int MAX_DEPTH = 16;

  // Width needed to hold an occupancy value from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One slot of the chain: a valid flag plus a payload register.
// The payload only changes when the slot is loaded, so a stalled or
// emptied slot keeps its last value.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,    // slot takes d this edge
  input  logic             unload,  // slot's entry moves on this edge
  input  logic             clear,   // discard the entry, payload untouched
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  // Occupancy flag: clear wins, a load refills, an unload without refill empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

  // Payload register: captures only on load, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register chain with valid/ready handshakes on both ends.
// Entries advance whenever the slot ahead can take them, so bubbles
// collapse and a free slot anywhere lets the input side accept.
// The ready chain is combinational from out_ready back to in_ready;
// payload always passes through DEPTH registers.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH   // legal range 1..16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CW = count_width(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] advance;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] data [DEPTH];

  logic in_fire;
  logic out_fire;

  // Ready/advance chain, evaluated from the output end back to stage 0.
  always_comb begin
    advance = '0;
    ready   = '0;
    advance[DEPTH-1] = valid[DEPTH-1] & out_ready;
    ready[DEPTH-1]   = ~valid[DEPTH-1] | advance[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      advance[i] = valid[i] & ready[i+1];
      ready[i]   = ~valid[i] | advance[i];
    end
  end

  assign in_ready  = ready[0] & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = advance[DEPTH-1];
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] stage_d;

    if (gi == 0) begin : g_head
      assign load[gi] = in_fire;
      assign stage_d  = in_data;
    end else begin : g_body
      // A flush freezes every payload register, so internal moves are gated too.
      assign load[gi] = advance[gi-1] & ~flush;
      assign stage_d  = data[gi-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[gi]),
      .unload (advance[gi]),
      .clear  (flush),
      .d      (stage_d),
      .valid  (valid[gi]),
      .q      (data[gi])
    );
  end

  // Occupancy counter tracking transfers in and out; flush empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_fire && !out_fire) begin
      count <= count + CW'(1);
    end else if (!in_fire && out_fire) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain (WIDTH=32, DEPTH=3): directed vector table,
// an asynchronous-reset sequence, and a randomized run against a
// queue-based reference model.
module tb_pipe_reg_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       count;

  int tests;
  int fails;

  pipe_reg_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        exp_ov;
    logic [31:0] exp_od;
    logic        chk_od;
    logic [1:0]  exp_cnt;
    logic        exp_ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                              input logic fl, input logic ov, input logic [31:0] od,
                              input logic chk, input logic [1:0] cnt, input logic ir);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.exp_ov = ov; v.exp_od = od; v.chk_od = chk; v.exp_cnt = cnt; v.exp_ir = ir;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the random phase.
  logic [31:0] q_data[$];
  int          q_stamp[$];

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_count", {30'b0, count}, 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // Streaming with the consumer always ready.
    vecs.push_back(mk(1, 32'h11, 1, 0, 0, 0,     0, 0, 1));
    vecs.push_back(mk(1, 32'h22, 1, 0, 0, 0,     0, 1, 1));
    vecs.push_back(mk(1, 32'h33, 1, 0, 0, 0,     0, 2, 1));
    vecs.push_back(mk(1, 32'h44, 1, 0, 1, 32'h11, 1, 3, 1));
    vecs.push_back(mk(0, 0,      1, 0, 1, 32'h22, 1, 3, 1));
    vecs.push_back(mk(0, 0,      1, 0, 1, 32'h33, 1, 2, 1));
    vecs.push_back(mk(0, 0,      1, 0, 1, 32'h44, 1, 1, 1));
    vecs.push_back(mk(0, 0,      1, 0, 0, 0,     0, 0, 1));
    // Fill with consumer stalled, then emit and accept on one edge.
    vecs.push_back(mk(1, 32'h11, 0, 0, 0, 0,     0, 0, 1));
    vecs.push_back(mk(1, 32'h22, 0, 0, 0, 0,     0, 1, 1));
    vecs.push_back(mk(1, 32'h33, 0, 0, 0, 0,     0, 2, 1));
    vecs.push_back(mk(1, 32'h44, 0, 0, 1, 32'h11, 1, 3, 0));
    vecs.push_back(mk(1, 32'h44, 0, 0, 1, 32'h11, 1, 3, 0));
    vecs.push_back(mk(1, 32'h44, 1, 0, 1, 32'h11, 1, 3, 1));
    vecs.push_back(mk(0, 0,      0, 0, 1, 32'h22, 1, 3, 0));
    vecs.push_back(mk(0, 0,      1, 0, 1, 32'h22, 1, 3, 1));
    vecs.push_back(mk(0, 0,      1, 0, 1, 32'h33, 1, 2, 1));
    vecs.push_back(mk(0, 0,      1, 0, 1, 32'h44, 1, 1, 1));
    vecs.push_back(mk(0, 0,      1, 0, 0, 0,     0, 0, 1));
    // Bubble with consumer stalled: entries compact toward the output.
    vecs.push_back(mk(1, 32'hA1, 0, 0, 0, 0,     0, 0, 1));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0,     0, 1, 1));
    vecs.push_back(mk(1, 32'hA2, 0, 0, 0, 0,     0, 1, 1));
    vecs.push_back(mk(0, 0,      0, 0, 1, 32'hA1, 1, 2, 1));
    vecs.push_back(mk(0, 0,      0, 0, 1, 32'hA1, 1, 2, 1));
    // Flush with two entries and a competing input; payloads stay put.
    vecs.push_back(mk(1, 32'hDEAD, 0, 1, 1, 32'hA1, 1, 2, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0, 32'hA1, 1, 0, 1));
    vecs.push_back(mk(1, 32'h55, 1, 0, 0, 32'hA1, 1, 0, 1));
    vecs.push_back(mk(0, 0,      1, 0, 0, 0,     0, 1, 1));
    vecs.push_back(mk(0, 0,      1, 0, 0, 0,     0, 1, 1));
    vecs.push_back(mk(0, 0,      1, 0, 1, 32'h55, 1, 1, 1));
    vecs.push_back(mk(0, 0,      1, 0, 0, 32'h55, 1, 0, 1));

    foreach (vecs[k]) begin
      in_valid  = vecs[k].iv;
      in_data   = vecs[k].id;
      out_ready = vecs[k].ordy;
      flush     = vecs[k].fl;
      #1;
      $display("[TB] vec %0d iv=%0b id=%h ordy=%0b fl=%0b -> ov=%0b od=%h cnt=%0d ir=%0b",
               k, in_valid, in_data, out_ready, flush, out_valid, out_data, count, in_ready);
      check("vec_out_valid", {31'b0, out_valid}, {31'b0, vecs[k].exp_ov});
      check("vec_count", {30'b0, count}, {30'b0, vecs[k].exp_cnt});
      check("vec_in_ready", {31'b0, in_ready}, {31'b0, vecs[k].exp_ir});
      if (vecs[k].chk_od) check("vec_out_data", out_data, vecs[k].exp_od);
      tick();
    end

    // Asynchronous reset while full, asserted between clock edges.
    flush = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data = 32'h61 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("prerst_count", {30'b0, count}, 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-cycle -> ov=%0b cnt=%0d od=%h", out_valid, count, out_data);
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_count", {30'b0, count}, 32'd0);
    check("arst_out_data", out_data, 32'd0);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h77;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check("postrst_count", {30'b0, count}, 32'd1);
    check("postrst_ov0", {31'b0, out_valid}, 32'd0);
    tick();
    check("postrst_ov1", {31'b0, out_valid}, 32'd0);
    tick();
    $display("[TB] post-reset entry -> ov=%0b od=%h", out_valid, out_data);
    check("postrst_ov2", {31'b0, out_valid}, 32'd1);
    check("postrst_od", out_data, 32'h77);
    repeat (3) tick();
    check("postrst_empty", {30'b0, count}, 32'd0);

    // Randomized traffic against the queue model.
    begin
      int cyc;
      int thr_in;
      int thr_out;
      logic exp_ir;
      logic exp_ov;
      logic in_fire;
      logic out_fire;
      q_data.delete();
      q_stamp.delete();
      cyc = 0;
      thr_in = 50;
      thr_out = 50;
      for (int n = 0; n < 10000; n++) begin
        if (n % 500 == 0) begin
          thr_in = int'($urandom_range(10, 95));
          thr_out = int'($urandom_range(10, 95));
        end
        in_valid  = ($urandom_range(0, 99) < thr_in);
        in_data   = $urandom;
        out_ready = ($urandom_range(0, 99) < thr_out);
        flush     = ($urandom_range(0, 99) == 0);
        #1;
        // A free slot anywhere, or a draining output, lets the input accept.
        exp_ir = !flush && ((q_data.size() < DEPTH) || out_ready);
        // The oldest entry shows up DEPTH edges after it was accepted.
        exp_ov = (q_data.size() > 0) && ((cyc - q_stamp[0]) >= DEPTH);
        check("rnd_count", 32'(count), 32'(q_data.size()));
        check("rnd_in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
        check("rnd_out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        if (exp_ov && out_valid) check("rnd_out_data", out_data, q_data[0]);
        in_fire  = in_valid && exp_ir;
        out_fire = exp_ov && out_ready;
        if (out_fire)
          $display("[TB] rnd cyc %0d out %h (queue %0d)", cyc, q_data[0], q_data.size());
        if (flush) begin
          q_data.delete();
          q_stamp.delete();
        end else begin
          if (out_fire) begin
            void'(q_data.pop_front());
            void'(q_stamp.pop_front());
          end
          if (in_fire) begin
            q_data.push_back(in_data);
            q_stamp.push_back(cyc);
          end
        end
        tick();
        cyc++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits per stage.
REQ-002 SHALL have parameter DEPTH, default 3, number of register stages; legal range 1..16.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all in-flight entries.
REQ-006 SHALL have port in_valid, input, 1, upstream has data on in_data.
REQ-007 SHALL have port in_data, input, WIDTH, upstream payload.
REQ-008 SHALL have port in_ready, output, 1, chain accepts in_data this cycle.
REQ-009 SHALL have port out_valid, output, 1, last stage holds valid data.
REQ-010 SHALL have port out_data, output, WIDTH, last-stage payload.
REQ-011 SHALL have port out_ready, input, 1, downstream consumes out_data this cycle.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1), number of valid stages.

Function
REQ-013 Stages SHALL be numbered 0 (input side) to DEPTH-1 (output side), each holding one valid bit and one WIDTH-bit data register.
REQ-014 Stage DEPTH-1 SHALL advance when its valid bit and out_ready are both 1; stage i<DEPTH-1 SHALL advance when valid[i]=1 and stage i+1 is ready.
REQ-015 Stage i SHALL be ready when valid[i]=0 or stage i advances (bubble collapse; ready chain is combinational).
REQ-016 in_ready SHALL equal stage-0 ready AND NOT flush.
REQ-017 A transfer in SHALL occur on a clock edge where in_valid=1 and in_ready=1; a transfer out where out_valid=1 and out_ready=1.
REQ-018 A stage data register SHALL load only when that stage accepts new data; otherwise it SHALL hold its value (values stay stable while out_valid=1 and out_ready=0).
REQ-019 out_valid SHALL equal valid[DEPTH-1]; out_data SHALL equal data[DEPTH-1]; no combinational path from in_data to out_data.
REQ-020 Latency SHALL be exactly DEPTH cycles from a transfer in to out_valid when no stage is stalled; sustained throughput SHALL be one transfer per cycle.
REQ-021 When full (count=DEPTH) with out_ready=1 and in_valid=1, the chain SHALL emit and accept on the same edge; count unchanged.
REQ-022 When full with out_ready=0, in_ready SHALL be 0 and every stage SHALL hold.
REQ-023 flush=1 SHALL clear all valid bits on the next edge, override any simultaneous transfer in, and leave data registers unchanged; a transfer out in that cycle still counts as consumed by downstream.
REQ-024 count SHALL be registered, updated each edge by +1 on transfer in, -1 on transfer out, both or neither unchanged, and forced to 0 on flush.
REQ-025 Entries SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-026 DEPTH=1 SHALL behave as one handshaked register with in_ready = !valid[0] | out_ready.

Reset
REQ-027 rst_n=0 SHALL immediately clear all valid bits, all data registers to 0, and count to 0, regardless of clk.
REQ-028 Reset asserted mid-transfer SHALL discard all entries; the first edge after rst_n rises SHALL accept normally.

Structure
REQ-029 Package pipe_pkg SHALL hold default WIDTH/DEPTH constants and a count-width constant function.
REQ-030 One sub-module pipe_stage (valid bit, data register, load/clear controls) SHALL be instantiated DEPTH times via generate.

Verification (WIDTH=32, DEPTH=3)
REQ-031 Stream 0x11,0x22,0x33,0x44 with out_ready=1 -> out_valid from cycle 3, outputs in order, one per cycle, count peaks at 3.
REQ-032 Fill 3 entries with out_ready=0 -> in_ready=0, count=3, out_data=0x11 stable; raise out_ready and in_valid -> accept and emit same edge, count stays 3.
REQ-033 Insert bubble (in_valid low one cycle) with out_ready=0 -> entries compact to stages 2,1; count=2; in_ready=1.
REQ-034 flush with 2 entries and in_valid=1 -> count=0, out_valid=0 next cycle, in_data not captured.
REQ-035 Assert rst_n=0 between edges while full -> out_valid, count, out_data go to 0 immediately.
REQ-036 Random valid/ready for 10000 cycles against a scoreboard queue -> zero order/loss mismatches; count matches queue depth every cycle.
